// File: rtl/usbf_dma_pkg.sv
// Shared definitions for the USB function core DMA arbitration logic.
// Holds the arbiter state encoding, the endpoint index width and a one-hot helper.
package usbf_dma_pkg;

  localparam int unsigned EP_W   = 4;
  localparam int unsigned MAX_EP = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StHold  = 2'd2
  } dma_state_e;

  function automatic logic [MAX_EP-1:0] ep_onehot(input logic [EP_W-1:0] ep);
    return MAX_EP'(1) << ep;
  endfunction

endpackage

// File: rtl/usbf_rr_pick.sv
// Rotating-priority encoder: returns the first set bit of vec_i searching upward
// from last_i+1 (modulo N). Purely combinational.
module usbf_rr_pick
  import usbf_dma_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0]    vec_i,
  input  logic [EP_W-1:0] last_i,
  output logic            valid_o,
  output logic [EP_W-1:0] idx_o
);

  int unsigned  pos;
  logic [N-1:0] rot;

  always_comb begin
    valid_o = |vec_i;
    idx_o   = '0;
    pos     = 0;
    rot     = '0;
    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    for (int unsigned off = N; off >= 1; off--) begin
      pos = (int'(last_i) + off) % N;
      rot = vec_i >> pos;
      if (rot[0]) begin
        idx_o = EP_W'(pos);
      end
    end
  end

endmodule

// File: rtl/usbf_dma_arb.sv
// Round-robin arbiter between per-endpoint DMA requests and the single external
// DMA channel, with a watchdog that aborts grants the external side never acks.
module usbf_dma_arb
  import usbf_dma_pkg::*;
#(
  parameter int unsigned NUM_EP = 16,
  parameter int unsigned TO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_EP-1:0] ep_dma_req,
  output logic [NUM_EP-1:0] ep_dma_ack,
  input  logic [NUM_EP-1:0] ep_en,
  output logic              dma_req_o,
  output logic [EP_W-1:0]   dma_ep_o,
  input  logic              dma_ack_i,
  output logic              to_err,
  input  logic              to_clr,
  output logic              busy
);

  localparam int unsigned     WD_W    = $clog2(TO_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_CYC - 1);

  dma_state_e        state_q, state_d;
  logic [EP_W-1:0]   cur_ep_q, cur_ep_d;
  logic [EP_W-1:0]   last_ep_q, last_ep_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              req_q, req_d;
  logic [EP_W-1:0]   ep_q, ep_d;
  logic [NUM_EP-1:0] ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [NUM_EP-1:0] eligible;
  logic [NUM_EP-1:0] live_vec;
  logic              live;
  logic              err_set;
  logic              pick_valid;
  logic [EP_W-1:0]   pick_idx;

  assign eligible = ep_dma_req & ep_en;
  // The granted endpoint is still live only while both its request and enable hold.
  assign live_vec = eligible >> cur_ep_q;
  assign live     = live_vec[0];

  usbf_rr_pick #(
    .N (NUM_EP)
  ) u_pick (
    .vec_i   (eligible),
    .last_i  (last_ep_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    cur_ep_d  = cur_ep_q;
    last_ep_d = last_ep_q;
    wd_d      = wd_q;
    ack_d     = '0;
    err_set   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          cur_ep_d  = pick_idx;
          last_ep_d = pick_idx;
          wd_d      = '0;
          state_d   = StGrant;
        end
      end
      StGrant: begin
        if (dma_ack_i) begin
          ack_d   = NUM_EP'(ep_onehot(cur_ep_q));
          state_d = StHold;
        end else if (!live) begin
          state_d = StHold;
        end else if (wd_q == WD_LAST) begin
          err_set = 1'b1;
          state_d = StHold;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 1'b1;
        end
      end
      StHold: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    err_d  = err_set ? 1'b1 : (to_clr ? 1'b0 : err_q);
    req_d  = (state_d == StGrant);
    ep_d   = req_d ? cur_ep_d : '0;
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cur_ep_q  <= '0;
      last_ep_q <= EP_W'(NUM_EP - 1);
      wd_q      <= '0;
      req_q     <= 1'b0;
      ep_q      <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_ep_q  <= cur_ep_d;
      last_ep_q <= last_ep_d;
      wd_q      <= wd_d;
      req_q     <= req_d;
      ep_q      <= ep_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign dma_req_o  = req_q;
  assign dma_ep_o   = ep_q;
  assign ep_dma_ack = ack_q;
  assign to_err     = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_usbf_dma_arb.sv
// Self-checking bench for usbf_dma_arb: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a transaction-level model.
module tb_usbf_dma_arb;

  localparam int NEP = 16;
  localparam int TOC = 4;

  logic            clk;
  logic            rst;
  logic [NEP-1:0]  ep_dma_req;
  logic [NEP-1:0]  ep_dma_ack;
  logic [NEP-1:0]  ep_en;
  logic            dma_req_o;
  logic [3:0]      dma_ep_o;
  logic            dma_ack_i;
  logic            to_err;
  logic            to_clr;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  usbf_dma_arb #(
    .NUM_EP (NEP),
    .TO_CYC (TOC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ep_dma_req (ep_dma_req),
    .ep_dma_ack (ep_dma_ack),
    .ep_en      (ep_en),
    .dma_req_o  (dma_req_o),
    .dma_ep_o   (dma_ep_o),
    .dma_ack_i  (dma_ack_i),
    .to_err     (to_err),
    .to_clr     (to_clr),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the channel, how long it has waited, and a one-cycle
  // cool-down after every release.
  int             m_owner;
  int             m_last;
  int             m_wait;
  bit             m_cool;
  bit             m_err;
  bit             m_found;
  int             m_i;
  logic [NEP-1:0] m_elig;
  logic [NEP-1:0] m_tmp;
  logic [NEP-1:0] e_ack;

  always @(posedge clk) begin
    e_ack = '0;
    if (!rst) begin
      m_owner = -1;
      m_last  = NEP - 1;
      m_wait  = 0;
      m_cool  = 1'b0;
      m_err   = 1'b0;
    end else if (m_cool) begin
      m_cool = 1'b0;
      if (to_clr) m_err = 1'b0;
    end else if (m_owner < 0) begin
      m_elig  = ep_dma_req & ep_en;
      m_found = 1'b0;
      for (int k = 1; k <= NEP; k++) begin
        m_i   = (m_last + k) % NEP;
        m_tmp = m_elig >> m_i;
        if (!m_found && m_tmp[0]) begin
          m_found = 1'b1;
          m_owner = m_i;
          m_last  = m_i;
          m_wait  = 0;
        end
      end
      if (to_clr) m_err = 1'b0;
    end else begin
      m_tmp = (ep_dma_req & ep_en) >> m_owner;
      if (dma_ack_i) begin
        e_ack   = NEP'(1) << m_owner;
        m_owner = -1;
        m_cool  = 1'b1;
        if (to_clr) m_err = 1'b0;
      end else if (!m_tmp[0]) begin
        m_owner = -1;
        m_cool  = 1'b1;
        if (to_clr) m_err = 1'b0;
      end else if (m_wait == TOC - 1) begin
        m_owner = -1;
        m_cool  = 1'b1;
        m_err   = 1'b1;
      end else begin
        m_wait++;
        if (to_clr) m_err = 1'b0;
      end
    end
    #1;
    chk("m_req", 32'(dma_req_o), 32'(m_owner >= 0));
    chk("m_ep", 32'(dma_ep_o), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("m_ack", 32'(ep_dma_ack), 32'(e_ack));
    chk("m_err", 32'(to_err), 32'(m_err));
    chk("m_busy", 32'(busy), 32'((m_owner >= 0) || m_cool));
    chk("ack_onehot", 32'($countones(ep_dma_ack) <= 1), 32'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int ep);
    bit ok;
    ok = 1'b0;
    ep = -1;
    for (int c = 0; c < 30 && !ok; c++) begin
      tick();
      if (dma_req_o) begin
        ok = 1'b1;
        ep = int'(dma_ep_o);
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_grant: dma_req_o not seen within 30 cycles at %0t", $time);
    end
  endtask

  // Acknowledge the current grant, check the pulse, drop the request, optionally re-raise.
  task automatic serve(output int ep, input bit reassert);
    wait_grant(ep);
    @(negedge clk);
    dma_ack_i = 1'b1;
    tick();
    chk("serve_ack", 32'(ep_dma_ack), (ep >= 0) ? (32'd1 << ep) : 32'd0);
    chk("serve_req_low", 32'(dma_req_o), 32'd0);
    @(negedge clk);
    dma_ack_i = 1'b0;
    if (ep >= 0) ep_dma_req[ep] = 1'b0;
    tick();
    if (reassert) begin
      @(negedge clk);
      if (ep >= 0) ep_dma_req[ep] = 1'b1;
    end
  endtask

  int         ep;
  int         hi;
  logic [NEP-1:0] acc;
  int         order_exp [6];
  int         r_bit;

  initial begin
    order_exp = '{0, 1, 15, 0, 1, 15};
    rst        = 1'b0;
    ep_dma_req = '0;
    ep_en      = '0;
    dma_ack_i  = 1'b0;
    to_clr     = 1'b0;
    tick();
    chk("rst_req", 32'(dma_req_o), 32'd0);
    chk("rst_ep", 32'(dma_ep_o), 32'd0);
    chk("rst_ack", 32'(ep_dma_ack), 32'd0);
    chk("rst_err", 32'(to_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single request, acked one cycle after grant.
    @(negedge clk);
    ep_en      = 16'hFFFF;
    ep_dma_req = 16'h0001;
    tick();
    chk("t1_req", 32'(dma_req_o), 32'd1);
    chk("t1_ep", 32'(dma_ep_o), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    dma_ack_i = 1'b1;
    tick();
    chk("t1_ack", 32'(ep_dma_ack), 32'h0001);
    chk("t1_req_low", 32'(dma_req_o), 32'd0);
    chk("t1_busy_hold", 32'(busy), 32'd1);
    @(negedge clk);
    dma_ack_i  = 1'b0;
    ep_dma_req = '0;
    tick();
    chk("t1_ack_once", 32'(ep_dma_ack), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Round-robin order from a fresh reset.
    @(negedge clk);
    rst = 1'b0;
    tick();
    @(negedge clk);
    rst        = 1'b1;
    ep_dma_req = 16'h8003;
    for (int n = 0; n < 6; n++) begin
      serve(ep, n < 5);
      chk("rr_order", 32'(ep), 32'(order_exp[n]));
    end
    @(negedge clk);
    ep_dma_req = '0;
    repeat (3) tick();

    // Masked endpoint 0 is never granted.
    @(negedge clk);
    ep_en      = 16'hFFFE;
    ep_dma_req = 16'h0003;
    serve(ep, 1'b0);
    chk("mask_ep", 32'(ep), 32'd1);
    hi  = 0;
    acc = '0;
    for (int n = 0; n < 6; n++) begin
      tick();
      hi  += int'(dma_req_o);
      acc |= ep_dma_ack;
    end
    chk("mask_no_grant", 32'(hi), 32'd0);
    chk("mask_no_ack", 32'(acc), 32'd0);
    @(negedge clk);
    ep_dma_req = '0;
    ep_en      = 16'hFFFF;
    repeat (2) tick();

    // Watchdog abort after exactly TOC grant cycles.
    @(negedge clk);
    ep_dma_req = 16'h0010;
    hi  = 0;
    acc = '0;
    for (int n = 0; n < 6; n++) begin
      tick();
      hi  += int'(dma_req_o);
      acc |= ep_dma_ack;
    end
    chk("to_len", 32'(hi), 32'(TOC));
    chk("to_err_set", 32'(to_err), 32'd1);
    chk("to_no_ack", 32'(acc), 32'd0);
    // Second abort coincident with a clear: the abort wins.
    wait_grant(ep);
    repeat (3) tick();
    @(negedge clk);
    to_clr = 1'b1;
    tick();
    chk("to_set_wins", 32'(to_err), 32'd1);
    chk("to_req_low", 32'(dma_req_o), 32'd0);
    @(negedge clk);
    to_clr     = 1'b0;
    ep_dma_req = '0;
    tick();
    @(negedge clk);
    to_clr = 1'b1;
    tick();
    chk("to_clr", 32'(to_err), 32'd0);
    @(negedge clk);
    to_clr = 1'b0;

    // Withdrawal drops the grant without an ack; withdrawal with ack still acks.
    @(negedge clk);
    ep_dma_req = 16'h0008;
    wait_grant(ep);
    chk("wd_ep", 32'(ep), 32'd3);
    @(negedge clk);
    ep_dma_req = '0;
    tick();
    chk("wd_req_low", 32'(dma_req_o), 32'd0);
    chk("wd_no_ack", 32'(ep_dma_ack), 32'd0);
    tick();
    @(negedge clk);
    ep_dma_req = 16'h0008;
    wait_grant(ep);
    @(negedge clk);
    ep_dma_req = '0;
    dma_ack_i  = 1'b1;
    tick();
    chk("wd_ack_wins", 32'(ep_dma_ack), 32'h0008);
    @(negedge clk);
    dma_ack_i = 1'b0;
    repeat (2) tick();

    // Asynchronous reset in the middle of a grant.
    @(negedge clk);
    ep_dma_req = 16'h0006;
    wait_grant(ep);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", 32'(dma_req_o), 32'd0);
    chk("arst_ack", 32'(ep_dma_ack), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ep", 32'(dma_ep_o), 32'd0);
    ep_dma_req = 16'h0003;
    @(negedge clk);
    rst = 1'b1;
    wait_grant(ep);
    chk("arst_first_ep", 32'(ep), 32'd0);
    @(negedge clk);
    ep_dma_req = '0;
    repeat (3) tick();

    // Randomized traffic; endpoints drop requests once acked.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ep_dma_req = ep_dma_req & ~ep_dma_ack;
      if ($urandom_range(2) == 0) begin
        r_bit = int'($urandom_range(NEP - 1));
        ep_dma_req = ep_dma_req | (NEP'(1) << r_bit);
      end
      if ($urandom_range(39) == 0) begin
        r_bit = int'($urandom_range(NEP - 1));
        ep_dma_req = ep_dma_req & ~(NEP'(1) << r_bit);
      end
      ep_en     = ($urandom_range(9) == 0) ? NEP'($urandom) : 16'hFFFF;
      dma_ack_i = ($urandom_range(3) == 0);
      to_clr    = ($urandom_range(11) == 0);
    end
    @(negedge clk);
    ep_dma_req = '0;
    dma_ack_i  = 1'b0;
    to_clr     = 1'b0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/usbf_dma_arb.md
# usbf_dma_arb

Round-robin arbiter between the per-endpoint register files' `dma_req` outputs and the core's single external DMA channel. It sits directly downstream of the endpoint register files: it consumes each endpoint's level `dma_req`, grants one endpoint at a time to the external DMA handshake, and returns a one-cycle `dma_ack` pulse to the granted endpoint. Non-existing endpoints tie `dma_req` low and are never granted. A watchdog aborts grants the external side never acknowledges.

## Interface
Parameters:
- `NUM_EP`, 16: number of endpoint request lines (1..16).
- `TO_CYC`, 255: cycles a grant may wait for `dma_ack_i` before abort (≥1).

Ports:
- `clk`  in  1  core clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `ep_dma_req`  in  NUM_EP  per-endpoint level request; held until acked.
- `ep_dma_ack`  out  NUM_EP  per-endpoint one-cycle ack pulse.
- `ep_en`  in  NUM_EP  arbitration mask; 0 = endpoint ignored.
- `dma_req_o`  out  1  request to external DMA.
- `dma_ep_o`  out  4  endpoint number of current grant; valid while `dma_req_o`=1.
- `dma_ack_i`  in  1  external DMA ack, sampled level.
- `to_err`  out  1  sticky watchdog-abort flag.
- `to_clr`  in  1  clears `to_err`.
- `busy`  out  1  high in any state except IDLE.

## Operation
- States: IDLE, GRANT, HOLD.
- IDLE: eligible = `ep_dma_req & ep_en`. If nonzero, pick first set bit searching upward from `last_ep+1` modulo NUM_EP; register index into `cur_ep` and `last_ep`, clear watchdog, go GRANT. If zero, stay.
- GRANT: `dma_req_o`=1, `dma_ep_o`=`cur_ep`. Priority per cycle: (1) `dma_ack_i`=1 -> pulse `ep_dma_ack[cur_ep]` next cycle, go HOLD; (2) else `ep_dma_req[cur_ep]`=0 or `ep_en[cur_ep]`=0 (withdrawal) -> go HOLD, no ack pulse; (3) else watchdog = TO_CYC-1 -> set `to_err`, go HOLD, no ack; (4) else watchdog +1.
- HOLD: one cycle, lets the endpoint deassert its request; `dma_req_o`=0; go IDLE.
- Watchdog width `$clog2(TO_CYC+1)`, saturates not wraps; reset only on entry to GRANT.
- `to_err`: set wins over simultaneous `to_clr`; otherwise `to_clr` clears next cycle.
- Ack in same cycle as withdrawal: ack wins (pulse issued).
- Outputs registered; `dma_ep_o` zero-extended index, driven 0 when not in GRANT.
- Reset values: state IDLE, `last_ep`=NUM_EP-1 (endpoint 0 wins first), `cur_ep`=0, watchdog 0, `dma_req_o`=0, `dma_ep_o`=0, `ep_dma_ack`=0, `to_err`=0, `busy`=0.
- Reset asserted mid-grant: all outputs return to reset values immediately (async); no ack pulse emitted.

## Timing
- Request seen in IDLE at edge N -> `dma_req_o`/`dma_ep_o` high from cycle N+1.
- `dma_ack_i` high at edge M -> `dma_req_o` low and `ep_dma_ack[cur_ep]` high during M+1 (exactly one cycle); HOLD at M+1; IDLE at M+2; next grant earliest M+3.
- Back-to-back grant throughput: one transfer per 3 cycles when `dma_ack_i` returns the cycle after request.
- Timeout: `dma_req_o` high exactly TO_CYC cycles, then low; `to_err` high from the following cycle.
- `ep_dma_ack` is never high for more than one cycle nor for more than one bit.

## Structure
- Shared package `usbf_dma_pkg`: state enum (IDLE/GRANT/HOLD), `EP_W`=4.
- Sub-module `usbf_rr_pick`: combinational rotating-priority encoder (vector, last index -> valid, index); reused by other core arbiters.

## Test plan
- Reset, then `ep_dma_req`=0x0001, `ep_en`=0xFFFF, ack one cycle after request -> `dma_ep_o`=0, `ep_dma_ack`=0x0001 one cycle, `busy` low 2 cycles after ack.
- `ep_dma_req`=0x8003 held, ack every grant -> grant order 0,1,15,0,1,15 (each endpoint drops req after its ack and reasserts).
- `ep_en`=0xFFFE with `ep_dma_req`=0x0003 -> only endpoint 1 granted; endpoint 0 never acked.
- TO_CYC=4, no `dma_ack_i` -> `dma_req_o` high 4 cycles, `to_err`=1, no ack pulse; `to_clr` and a second timeout in same cycle -> `to_err` stays 1.
- Withdraw `ep_dma_req[3]` during GRANT -> `dma_req_o` drops next cycle, no ack; withdrawal coincident with `dma_ack_i` -> ack pulse issued.
- Assert `rst` mid-GRANT -> `dma_req_o`, `ep_dma_ack`, `busy` 0 immediately; after release endpoint 0 has first priority.
